rom_stream_reader: RTL and testbench

//  Sequencer upstream of the 16x8 combinational lookup ROM.
//  - On a start request, walks a block of ROM addresses, wrapping 15->0.
//  - Captures each data word and streams it out over a valid/ready interface at up to one word per clock.
//  - Flags the final word of the block and pulses done when the block completes.

---
 rtl/rom_stream_reader_pkg.sv | 15 +
 rtl/rom_stream_reader.sv | 123 ++++++++++++
 tb/tb_rom_stream_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and defaults for the ROM stream reader.
// FSM encoding plus default ROM geometry.
package rom_stream_reader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rom_stream_reader.sv
// Walks a block of ROM addresses and streams the words out
// over a valid/ready port with last-word flag and done pulse.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              hs;
  logic              load;
  logic              kill;

  assign hs   = valid_q && out_ready;
  assign kill = abort && (state_q != ST_IDLE);
  assign load = (state_q == ST_STREAM)
             && (rem_q != '0)
             && (!valid_q || out_ready)
             && !abort;

  // Next-state, pointer and output-register logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (load) begin
      data_d  = rom_data;
      valid_d = 1'b1;
      last_d  = (rem_q == CNT_W'(1));
      ptr_d   = ptr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_d   = base_addr;
            rem_d   = count;
            state_d = ST_STREAM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STREAM: begin
        if (rem_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!valid_d) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // A cancel lets any same-cycle handshake finish, then empties the block.
    if (kill) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      rem_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rom_addr  = ptr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader.
// Directed and random blocks against a queue-based word model.
module tb_rom_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       abort;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  rom_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  assign rom_data = {4'hA, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready always high, mode 1: stall 3 cycles on word 1,
  // mode 2: random ready.
  task automatic run_block(input logic [3:0] b,
                           input logic [4:0] c,
                           input int mode);
    logic [7:0] exp_q[$];
    int idx = 0;
    int stall = 0;
    bit exp_done;
    bit done_seen = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    for (int i = 0; i < int'(c); i++)
      exp_q.push_back({4'hA, 4'(int'(b) + i)});
    exp_done = (c == 0);
    start = 1'b1;
    base_addr = b;
    count = c;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    for (int cyc = 0; cyc < 120; cyc++) begin
      chk("done", done, exp_done);
      if (done) begin
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        done_seen = 1;
        break;
      end
      exp_done = 0;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) begin
        out_ready = !(out_valid && idx == 1 && stall < 3);
        if (!out_ready) stall++;
      end else out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (mode == 0 && c != 0 && idx < int'(c))
        chk("latency_tput", out_valid, cyc >= 1);
      prev_stall = 0;
      if (out_valid) begin
        if (idx >= int'(c)) begin
          chk("extra_word", out_valid, 0);
        end else begin
          chk("data", out_data, exp_q[idx]);
          chk("last", out_last, idx == int'(c) - 1);
          if (out_ready) begin
            idx++;
            exp_done = (idx == int'(c));
          end else begin
            prev_stall = 1;
            prev_data = out_data;
            prev_last = out_last;
          end
        end
      end
      @(negedge clk);
    end
    if (!done_seen) chk("timeout_done", done_seen, 1);
    chk("word_count", idx, c);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // reset in the middle of a block
    start = 1'b1;
    base_addr = 4'd5;
    count = 5'd8;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_w0", out_data, 8'hA5);
    @(negedge clk);
    chk("rst_w1", out_data, 8'hA6);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midrst");
    @(negedge clk);
    chk_idle_outputs("midrst_hold");
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);

    run_block(4'd2, 5'd3, 0);
    run_block(4'd14, 5'd4, 0);
    run_block(4'd0, 5'd3, 1);
    run_block(4'd0, 5'd0, 0);
    run_block(4'd9, 5'd16, 0);

    // abort during the second word, start ignored while busy
    start = 1'b1;
    base_addr = 4'd3;
    count = 5'd8;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_lat", out_valid, 0);
    @(negedge clk);
    chk("ab_w0", out_data, 8'hA3);
    start = 1'b1;
    base_addr = 4'd9;
    count = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("ab_w1", out_data, 8'hA4);
    chk("ab_w1_valid", out_valid, 1);
    abort = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", out_valid, 0);
    chk("ab_last", out_last, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_no_done", done, 0);
      chk("ab_stay_idle", busy, 0);
    end
    run_block(4'd6, 5'd2, 0);

    for (int n = 0; n < 10; n++)
      run_block(4'($urandom_range(0, 15)),
                5'($urandom_range(0, 16)), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
